seq_det_1011: RTL and testbench

Serial pattern detector that consumes the registered bit stream produced by the JK-based D flip-flop stage (its `q` drives `din` here). It recognises the sequence 1-0-1-1 (first bit oldest) with a Moore FSM and emits a one-cycle `detect` pulse per match. It also keeps a saturating match counter and a 4-bit history of the accepted bits for debug and readback. Overlapping matches are selectable by parameter.

---
 rtl/seq_det_1011.sv | 101 ++++++++++
 tb/tb_seq_det_1011.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_det_1011.sv
// Moore detector for the serial pattern 1-0-1-1 (oldest bit first), with a saturating
// match counter and a 4-bit history of accepted bits.
module seq_det_1011 #(
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cnt_clr,
    output logic             detect,
    output logic [CNT_W-1:0] det_count,
    output logic [3:0]       history,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StS1   = 3'd1,
        StS10  = 3'd2,
        StS101 = 3'd3,
        StDet  = 3'd4
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               r_detect;
    logic               w_detect_d;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_d;
    logic [3:0]         r_history;
    logic [3:0]         w_history_d;
    logic               w_cnt_sat;

    // Next-state logic; illegal codes fall back to idle regardless of din_valid.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (din_valid) w_state_d = din ? StS1 : StIdle;
            end
            StS1: begin
                if (din_valid) w_state_d = din ? StS1 : StS10;
            end
            StS10: begin
                if (din_valid) w_state_d = din ? StS101 : StIdle;
            end
            StS101: begin
                if (din_valid) w_state_d = din ? StDet : StS10;
            end
            StDet: begin
                if (din_valid) begin
                    if (din) begin
                        w_state_d = StS1;
                    end else begin
                        w_state_d = OVERLAP ? StS10 : StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // A held DET state never re-fires: only an accepted bit can pulse detect.
    always_comb begin
        w_detect_d  = din_valid && (w_state_d == StDet);
        w_history_d = din_valid ? {r_history[2:0], din} : r_history;
    end

    assign w_cnt_sat = (r_count == {CNT_W{1'b1}});

    always_comb begin
        w_count_d = r_count;
        if (cnt_clr) begin
            w_count_d = '0;
        end else if (w_detect_d && !w_cnt_sat) begin
            w_count_d = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_detect  <= 1'b0;
            r_count   <= '0;
            r_history <= 4'b0000;
        end else begin
            r_state   <= w_state_d;
            r_detect  <= w_detect_d;
            r_count   <= w_count_d;
            r_history <= w_history_d;
        end
    end

    assign detect    = r_detect;
    assign det_count = r_count;
    assign history   = r_history;
    assign state_o   = r_state;

endmodule

// File: tb/tb_seq_det_1011.sv
// Directed bench for seq_det_1011: overlap, non-overlap and 2-bit saturating instances
// share one stimulus stream.
module tb_seq_det_1011;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       cnt_clr;

    logic       a_detect, b_detect, c_detect;
    logic [7:0] a_count, b_count;
    logic [1:0] c_count;
    logic [3:0] a_hist, b_hist, c_hist;
    logic [2:0] a_state, b_state, c_state;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_1011 #(.OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .detect(a_detect), .det_count(a_count), .history(a_hist), .state_o(a_state)
    );

    seq_det_1011 #(.OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .detect(b_detect), .det_count(b_count), .history(b_hist), .state_o(b_state)
    );

    seq_det_1011 #(.OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .detect(c_detect), .det_count(c_count), .history(c_hist), .state_o(c_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic d, input logic v, input logic clr, input logic r);
        @(negedge clk);
        din       = d;
        din_valid = v;
        cnt_clr   = clr;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic det, input logic [7:0] cnt,
                         input logic [3:0] hist, input logic [2:0] st);
        chk({tag, " detect"}, 32'(a_detect), 32'(det));
        chk({tag, " count"},  32'(a_count),  32'(cnt));
        chk({tag, " history"}, 32'(a_hist),  32'(hist));
        chk({tag, " state"},  32'(a_state),  32'(st));
    endtask

    logic [6:0] seq3;
    logic [6:0] exp_a3;
    logic [6:0] exp_b3;
    logic [2:0] gap_din;

    initial begin
        din = 1'b0; din_valid = 1'b0; cnt_clr = 1'b0; rst = 1'b0;

        // 1. Reset with din_valid/din high
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_a("rst1", 1'b0, 8'd0, 4'b0000, 3'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_a("rst2", 1'b0, 8'd0, 4'b0000, 3'd0);
        chk("rst2 c count", 32'(c_count), 32'd0);

        // 2. Basic match
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_a("basic b1", 1'b0, 8'd0, 4'b0001, 3'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_a("basic b2", 1'b0, 8'd0, 4'b0010, 3'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_a("basic b3", 1'b0, 8'd0, 4'b0101, 3'd3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_a("basic b4", 1'b1, 8'd1, 4'b1011, 3'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_a("basic hold", 1'b0, 8'd1, 4'b1011, 3'd4);

        // 3. Overlap vs restart on 1011011 (index 6 applied first)
        step(1'b0, 1'b0, 1'b0, 1'b1);
        seq3   = 7'b1011011;
        exp_a3 = 7'b0001001;
        exp_b3 = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            step(seq3[i], 1'b1, 1'b0, 1'b0);
            chk($sformatf("ovl a bit%0d", 7 - i), 32'(a_detect), 32'(exp_a3[i]));
            chk($sformatf("ovl b bit%0d", 7 - i), 32'(b_detect), 32'(exp_b3[i]));
        end
        chk("ovl a count", 32'(a_count), 32'd2);
        chk("ovl b count", 32'(b_count), 32'd1);

        // 4. Valid gaps freeze state and history
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_a("gap first", 1'b0, 8'd0, 4'b0001, 3'd1);
        gap_din = 3'b010;
        for (int i = 0; i < 3; i++) begin
            step(gap_din[i], 1'b0, 1'b0, 1'b0);
            chk_a($sformatf("gap idle%0d", i), 1'b0, 8'd0, 4'b0001, 3'd1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_a("gap b2", 1'b0, 8'd0, 4'b0010, 3'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_a("gap b3", 1'b0, 8'd0, 4'b0101, 3'd3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_a("gap b4", 1'b1, 8'd1, 4'b1011, 3'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_a("gap det hold1", 1'b0, 8'd1, 4'b1011, 3'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_a("gap det hold2", 1'b0, 8'd1, 4'b1011, 3'd4);

        // 5. Saturation of the 2-bit counter, then clear racing a match
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int m = 1; m <= 5; m++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("sat det m%0d", m), 32'(c_detect), 32'd1);
            chk($sformatf("sat cnt m%0d", m), 32'(c_count), (m > 3) ? 32'd3 : 32'(m));
        end
        chk("sat a count", 32'(a_count), 32'd5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat hold c det", 32'(c_detect), 32'd0);
        chk("sat hold c cnt", 32'(c_count), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr c det", 32'(c_detect), 32'd1);
        chk("clr c cnt", 32'(c_count), 32'd0);
        chk("clr a cnt", 32'(a_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr c after", 32'(c_count), 32'd0);

        // 6. Reset mid-sequence discards progress
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid pre state", 32'(a_state), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_a("mid rst", 1'b0, 8'd0, 4'b0000, 3'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_a("mid after", 1'b0, 8'd0, 4'b0001, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
